// File: rtl/tm_clause_scheduler_pkg.sv
// Shared types and constants for the Tsetlin-machine clause scheduler.
package tm_clause_scheduler_pkg;

   localparam int N_CLAUSE_DEF = 4;
   localparam int N_FEAT_DEF   = 2;
   localparam int LIT_W        = 2 * N_FEAT_DEF;
   localparam int SCORE_W      = 3;

   localparam logic [1:0] CLASS_NONE    = 2'b00;
   localparam logic [1:0] CLASS0_ONEHOT = 2'b01;
   localparam logic [1:0] CLASS1_ONEHOT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EVAL   = 2'd1,
      ST_DECIDE = 2'd2,
      ST_HOLD   = 2'd3
   } sched_state_e;

endpackage

// File: rtl/tm_clause_scheduler_if.sv
// Sample/result/config bundle between a client (master) and the scheduler (slave).
interface tm_clause_scheduler_if
   import tm_clause_scheduler_pkg::*;
#(
   parameter int N_CLAUSE = 4,
   parameter int N_FEAT   = 2
) ();
   localparam int ADDR_W = $clog2(2 * N_CLAUSE);
   localparam int LW     = 2 * N_FEAT;

   logic                      cfg_we;
   logic [ADDR_W-1:0]         cfg_addr;
   logic [LW-1:0]             cfg_data;
   logic                      cfg_busy;
   logic                      in_valid;
   logic                      in_ready;
   logic [N_FEAT-1:0]         features;
   logic                      out_valid;
   logic                      out_ready;
   logic [1:0]                final_class;
   logic signed [SCORE_W-1:0] score0;
   logic signed [SCORE_W-1:0] score1;

   modport master (
      output cfg_we, cfg_addr, cfg_data, in_valid, features, out_ready,
      input  cfg_busy, in_ready, out_valid, final_class, score0, score1
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, in_valid, features, out_ready,
      output cfg_busy, in_ready, out_valid, final_class, score0, score1
   );
endinterface

// File: rtl/tm_clause_eval.sv
// Combinational conjunctive clause: AND of non-excluded literals; an empty clause yields 0.
module tm_clause_eval
   import tm_clause_scheduler_pkg::*;
#(
   parameter int LW = LIT_W
) (
   input  logic [LW-1:0] lit,
   input  logic [LW-1:0] excl,
   output logic          clause_out
);

   // Empty clauses are forced low so an unconfigured machine never votes.
   always_comb begin
      clause_out = (&(lit | excl)) & ~(&excl);
   end

endmodule

// File: rtl/tm_clause_scheduler.sv
// Two-class Tsetlin clause scheduler: one shared clause evaluator swept over all
// clauses, one per cycle, accumulating signed class votes before a decision.
module tm_clause_scheduler
   import tm_clause_scheduler_pkg::*;
#(
   parameter int N_CLAUSE = 4,
   parameter int N_FEAT   = 2
) (
   input logic            clk,
   input logic            rst,
   tm_clause_scheduler_if.slave bus
);

   localparam int NLIT    = 2 * N_FEAT;
   localparam int N_TOTAL = 2 * N_CLAUSE;
   localparam int IDX_W   = $clog2(N_TOTAL);
   localparam int HALF    = N_CLAUSE / 2;

   sched_state_e              state_r;
   sched_state_e              state_next_s;
   logic [IDX_W-1:0]          idx_r;
   logic [N_FEAT-1:0]         feat_r;
   logic [NLIT-1:0]           excl_r [N_TOTAL];
   logic signed [SCORE_W-1:0] score0_r;
   logic signed [SCORE_W-1:0] score1_r;
   logic [1:0]                class_r;
   logic                      out_valid_r;

   logic                      accept_s;
   logic                      cfg_wr_s;
   logic                      eval_en_s;
   logic                      decide_s;
   logic                      hold_exit_s;
   logic                      last_idx_s;
   logic [NLIT-1:0]           lit_s;
   logic [NLIT-1:0]           excl_sel_s;
   logic                      clause_out_s;
   logic                      is_class1_s;
   logic                      is_pos_s;
   logic [IDX_W-1:0]          k_s;
   logic signed [SCORE_W-1:0] delta_s;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   assign last_idx_s = (idx_r == IDX_W'(N_TOTAL - 1));

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) state_next_s = ST_EVAL;
            else              state_next_s = ST_IDLE;
         end
         ST_EVAL: begin
            if (last_idx_s) state_next_s = ST_DECIDE;
            else            state_next_s = ST_EVAL;
         end
         ST_DECIDE: state_next_s = ST_HOLD;
         ST_HOLD: begin
            if (out_valid_r && bus.out_ready) state_next_s = ST_IDLE;
            else                              state_next_s = ST_HOLD;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Per-state control strobes; config writes are only honoured while idle.
   always_comb begin
      accept_s    = 1'b0;
      cfg_wr_s    = 1'b0;
      eval_en_s   = 1'b0;
      decide_s    = 1'b0;
      hold_exit_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            accept_s = bus.in_valid;
            cfg_wr_s = bus.cfg_we;
         end
         ST_EVAL:   eval_en_s = 1'b1;
         ST_DECIDE: decide_s  = 1'b1;
         ST_HOLD:   hold_exit_s = out_valid_r & bus.out_ready;
         default: begin
            accept_s = 1'b0;
         end
      endcase
   end

   // Exclude-mask register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_TOTAL; i++) excl_r[i] <= {NLIT{1'b1}};
      end else if (cfg_wr_s) begin
         excl_r[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   // Clause selection and vote polarity for the current sweep index.
   always_comb begin
      lit_s       = {~feat_r, feat_r};
      excl_sel_s  = excl_r[idx_r];
      is_class1_s = (idx_r >= IDX_W'(N_CLAUSE));
      if (is_class1_s) k_s = idx_r - IDX_W'(N_CLAUSE);
      else             k_s = idx_r;
      is_pos_s = (k_s < IDX_W'(HALF));
      if (!clause_out_s)  delta_s = {SCORE_W{1'b0}};
      else if (is_pos_s)  delta_s = SCORE_W'(1);
      else                delta_s = {SCORE_W{1'b1}};
   end

   tm_clause_eval #(.LW(NLIT)) u_eval (
      .lit        (lit_s),
      .excl       (excl_sel_s),
      .clause_out (clause_out_s)
   );

   // Sample capture, sweep counter and vote accumulators.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r    <= {IDX_W{1'b0}};
         feat_r   <= {N_FEAT{1'b0}};
         score0_r <= {SCORE_W{1'b0}};
         score1_r <= {SCORE_W{1'b0}};
      end else if (accept_s) begin
         idx_r    <= {IDX_W{1'b0}};
         feat_r   <= bus.features;
         score0_r <= {SCORE_W{1'b0}};
         score1_r <= {SCORE_W{1'b0}};
      end else if (eval_en_s) begin
         idx_r <= idx_r + IDX_W'(1);
         if (is_class1_s) score1_r <= score1_r + delta_s;
         else             score0_r <= score0_r + delta_s;
      end
   end

   // Decision and result-valid; valid lags HOLD entry by one cycle and drops on handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         class_r     <= CLASS_NONE;
         out_valid_r <= 1'b0;
      end else begin
         if (decide_s) begin
            class_r <= (score1_r > score0_r) ? CLASS1_ONEHOT : CLASS0_ONEHOT;
         end
         out_valid_r <= (state_r == ST_HOLD) && !hold_exit_s;
      end
   end

   assign bus.in_ready    = (state_r == ST_IDLE);
   assign bus.cfg_busy    = (state_r != ST_IDLE);
   assign bus.out_valid   = out_valid_r;
   assign bus.final_class = class_r;
   assign bus.score0      = score0_r;
   assign bus.score1      = score1_r;

endmodule

// File: tb/tb_tm_clause_scheduler.sv
// Scoreboard bench for tm_clause_scheduler: directed scenarios plus randomized traffic.
module tb_tm_clause_scheduler;
   import tm_clause_scheduler_pkg::*;

   localparam int NC = 4;
   localparam int NF = 2;
   localparam int NT = 2 * NC;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   rand_bp = 1'b0;

   tm_clause_scheduler_if #(.N_CLAUSE(NC), .N_FEAT(NF)) bus ();

   tm_clause_scheduler #(.N_CLAUSE(NC), .N_FEAT(NF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0] fc;
      int         s0;
      int         s1;
      int         acc;
   } exp_t;

   exp_t       sb_q[$];
   logic [3:0] mdl_mask [NT];

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endfunction

   // Reference model: each class sums +1 for firing positive clauses, -1 for negative ones.
   function automatic exp_t predict(input logic [1:0] f);
      exp_t       e;
      int         s0, s1, v;
      logic [3:0] lit, m;
      lit = {~f, f};
      s0 = 0;
      s1 = 0;
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < NC; k++) begin
            m = mdl_mask[c * NC + k];
            if (m != 4'hF && (lit | m) == 4'hF) begin
               v = (k < NC / 2) ? 1 : -1;
               if (c == 0) s0 += v;
               else        s1 += v;
            end
         end
      end
      e.s0 = s0;
      e.s1 = s1;
      e.fc = (s1 > s0) ? 2'b10 : 2'b01;
      e.acc = 0;
      return e;
   endfunction

   logic prev_ov = 1'b0;

   // Monitor: latency on rising out_valid, content on each handshake.
   always @(negedge clk) begin
      if (rst) begin
         prev_ov = 1'b0;
      end else begin
         if (bus.out_valid && !prev_ov) begin
            if (sb_q.size() == 0) fail_now("unexpected_out_valid: got out_valid=1 expected no pending result");
            else chk("latency", cyc - sb_q[0].acc, 10);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               fail_now("spurious_result: got handshake expected none");
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("final_class", int'(bus.final_class), int'(e.fc));
               chk("score0", int'($signed(bus.score0)), e.s0);
               chk("score1", int'($signed(bus.score1)), e.s1);
            end
         end
         prev_ov = bus.out_valid;
      end
   end

   // Random downstream backpressure when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) fail_now("wait_idle_timeout: got in_ready low expected high");
   endtask

   task automatic cfg_write(input int a, input logic [3:0] d);
      wait_idle();
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'(a);
      bus.cfg_data = d;
      tick();
      bus.cfg_we = 1'b0;
      mdl_mask[a] = d;
   endtask

   task automatic clear_masks();
      for (int i = 0; i < NT; i++) cfg_write(i, 4'hF);
   endtask

   task automatic send(input logic [1:0] f, input bit we, input int a, input logic [3:0] d);
      int   n = 0;
      exp_t e;
      bus.features = f;
      bus.in_valid = 1'b1;
      bus.cfg_we   = we;
      bus.cfg_addr = 3'(a);
      bus.cfg_data = d;
      while (bus.in_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         fail_now("send_timeout: got in_ready low expected high");
         bus.in_valid = 1'b0;
         bus.cfg_we   = 1'b0;
      end else begin
         tick();
         bus.in_valid = 1'b0;
         bus.cfg_we   = 1'b0;
         if (we) mdl_mask[a] = d;
         e = predict(f);
         e.acc = cyc;
         sb_q.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() > 0 && n < 400) begin
         tick();
         n++;
      end
      if (n >= 400) fail_now("drain_timeout: got pending results expected none");
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
      chk({tag, "_cfg_busy"}, int'(bus.cfg_busy), 0);
      chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_final_class"}, int'(bus.final_class), 0);
      chk({tag, "_score0"}, int'($signed(bus.score0)), 0);
      chk({tag, "_score1"}, int'($signed(bus.score1)), 0);
   endtask

   initial begin
      int n;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = 3'd0;
      bus.cfg_data  = 4'd0;
      bus.in_valid  = 1'b0;
      bus.features  = 2'd0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NT; i++) mdl_mask[i] = 4'hF;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("reset");

      // Tie: all clauses empty.
      for (int f = 0; f < 4; f++) send(2'(f), 1'b0, 0, 4'h0);
      wait_drain();

      // Class-0 win.
      cfg_write(0, 4'b1110);
      cfg_write(1, 4'b0111);
      send(2'b01, 1'b0, 0, 4'h0);
      wait_drain();
      clear_masks();

      // Class-1 win with a firing negative class-0 clause.
      cfg_write(4, 4'b1110);
      cfg_write(5, 4'b1110);
      cfg_write(2, 4'b1110);
      send(2'b01, 1'b0, 0, 4'h0);
      wait_drain();

      // Backpressure in HOLD.
      bus.out_ready = 1'b0;
      send(2'b10, 1'b0, 0, 4'h0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.out_valid !== 1'b1 && n < 40);
      if (n >= 40) fail_now("bp_wait: got out_valid low expected high");
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", int'(bus.out_valid), 1);
         chk("bp_in_ready", int'(bus.in_ready), 0);
         if (sb_q.size() > 0) begin
            chk("bp_final_class", int'(bus.final_class), int'(sb_q[0].fc));
            chk("bp_score0", int'($signed(bus.score0)), sb_q[0].s0);
            chk("bp_score1", int'($signed(bus.score1)), sb_q[0].s1);
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", int'(bus.in_ready), 1);
      chk("bp_release_out_valid", int'(bus.out_valid), 0);
      clear_masks();

      // Config write while busy is dropped.
      send(2'b01, 1'b0, 0, 4'h0);
      repeat (3) tick();
      chk("busy_cfg_busy", int'(bus.cfg_busy), 1);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'd0;
      bus.cfg_data = 4'b1110;
      tick();
      bus.cfg_we = 1'b0;
      wait_drain();
      send(2'b01, 1'b0, 0, 4'h0);
      wait_drain();

      // Write coinciding with acceptance is used by that sample.
      send(2'b01, 1'b1, 4, 4'b1110);
      wait_drain();
      clear_masks();

      // Reset at sweep index 4.
      cfg_write(0, 4'b1110);
      cfg_write(1, 4'b0111);
      send(2'b01, 1'b0, 0, 4'h0);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb_q.delete();
      for (int i = 0; i < NT; i++) mdl_mask[i] = 4'hF;
      @(negedge clk);
      check_reset_state("mid_eval_reset");
      repeat (15) tick();
      send(2'b01, 1'b0, 0, 4'h0);
      wait_drain();

      // Randomized traffic with random backpressure.
      rand_bp = 1'b1;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0) cfg_write(int'($urandom_range(0, NT - 1)), 4'($urandom));
         send(2'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, NT - 1)), 4'($urandom));
      end
      wait_drain();
      rand_bp = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tm_clause_scheduler.md
TM_CLAUSE_SCHEDULER -- requirements
Module: tm_clause_scheduler

Interface
REQ-001 SHALL have parameter N_CLAUSE, default 4, clauses per class (2 classes fixed; clauses 0..N/2-1 positive, rest negative).
REQ-002 SHALL have parameter N_FEAT, default 2, Boolean features per sample; literal width 2*N_FEAT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cfg_we  input  1  exclude-state write strobe.
REQ-006 cfg_addr  input  3  {class, clause k}; bit 2 = class.
REQ-007 cfg_data  input  4  exclude mask, bit i = 1 excludes literal i.
REQ-008 cfg_busy  output  1  high when state != IDLE; writes dropped while high.
REQ-009 in_valid  input  1  sample offered.
REQ-010 in_ready  output  1  high only in IDLE.
REQ-011 features  input  2  sample; latched on acceptance.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 final_class  output  2  one-hot winner: 01 = class 0, 10 = class 1.
REQ-015 score0, score1  output  3 each  signed two's-complement class vote sums.

Function
REQ-016 Literal vector SHALL be {~f1, ~f0, f1, f0}, bits [3:0].
REQ-017 Clause output SHALL be AND over i of (lit[i] | excl[i]); all-excluded clause SHALL output 0.
REQ-018 States SHALL be IDLE, EVAL, DECIDE, HOLD.
REQ-019 IDLE: in_valid & in_ready SHALL latch features, clear scores and counter, go to EVAL.
REQ-020 EVAL: one clause per cycle, index 0..7 (class 0 k0..k3, then class 1 k0..k3); positive clause adds its output, negative subtracts; after index 7 go to DECIDE.
REQ-021 Score range SHALL be -2..+2; no saturation required.
REQ-022 DECIDE: final_class = 10 if score1 > score0, else 01 (tie -> class 0); go to HOLD.
REQ-023 HOLD: out_valid high; outputs stable until out_valid & out_ready, then IDLE in the next cycle.
REQ-024 Latency: out_valid SHALL rise exactly 10 cycles after the accepting edge.
REQ-025 in_ready SHALL be low in EVAL, DECIDE, HOLD; no overlap of samples.
REQ-026 cfg_we in IDLE SHALL write register cfg_addr the same edge; cfg_we with simultaneous acceptance SHALL be written before evaluation begins (new mask used).
REQ-027 cfg_we while cfg_busy SHALL be ignored with no side effect.

Reset
REQ-028 rst SHALL force IDLE, counter 0, out_valid 0, final_class 00, scores 0, in_ready 1 next cycle, from any state including mid-EVAL.
REQ-029 Exclude registers SHALL reset to 4'b1111 (all clauses empty, output 0).

Structure
REQ-030 Shared package SHALL hold state enum, literal width, score width, class one-hot codes.
REQ-031 One sub-module tm_clause_eval (combinational clause function of REQ-017); scheduler instantiates it once and time-multiplexes it.

Verification
REQ-032 Class-0 win: masks c0k0=1110, c0k1=0111, others 1111; features=01 -> final_class=01, score0=+2, score1=0, out_valid at cycle 10.
REQ-033 Class-1 win: c1k0=c1k1=1110, c0k2=1110, others 1111; features=01 -> final_class=10, score0=-1, score1=+2.
REQ-034 Tie: all masks 1111, any features -> final_class=01, scores 0,0.
REQ-035 Backpressure: hold out_ready low 5 cycles in HOLD -> outputs constant, in_ready low; release -> IDLE next cycle.
REQ-036 Config during busy: write c0k0=1110 in EVAL -> ignored; next sample uses old mask.
REQ-037 Reset at EVAL index 4 -> IDLE, out_valid 0, masks 1111, no result emitted.
